// File: rtl/snd_arbiter_if.sv
// Request/playback bundle between the two player blocks, the sound arbiter and the audio path.
// master = request side (players / audio sink), slave = arbiter.
interface snd_arbiter_if #(
    parameter int unsigned CODE_W = 13
);
    logic              req1_valid;
    logic [CODE_W-1:0] req1_code;
    logic              req1_ready;
    logic              req2_valid;
    logic [CODE_W-1:0] req2_code;
    logic              req2_ready;
    logic [CODE_W-1:0] audio;
    logic              audio_enable;
    logic              busy_player1;
    logic              busy_player2;

    modport master (
        output req1_valid, req1_code, req2_valid, req2_code,
        input  req1_ready, req2_ready, audio, audio_enable, busy_player1, busy_player2
    );

    modport slave (
        input  req1_valid, req1_code, req2_valid, req2_code,
        output req1_ready, req2_ready, audio, audio_enable, busy_player1, busy_player2
    );
endinterface

// File: rtl/snd_arbiter.sv
// Round-robin arbiter sharing one sound-effect channel between two players (play, then gap).
// Define SND_PREEMPT_EN to let a high-priority pending clip cut off a low-priority one.
module snd_arbiter #(
    parameter int unsigned       CODE_W      = 13,
    parameter logic [25:0]       CLIP_CYCLES = 26'd4_000_000,
    parameter logic [25:0]       GAP_CYCLES  = 26'd80_000,
    parameter logic [CODE_W-1:0] PRIO_MASK   = CODE_W'(13'h1F00)
) (
    input  logic         clk,
    input  logic         RST,
    snd_arbiter_if.slave bus
);

`ifdef SND_PREEMPT_EN
    localparam logic PREEMPT_EN = 1'b1;
`else
    localparam logic PREEMPT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state, state_n;
    logic [25:0]       cnt, cnt_n;
    logic [CODE_W-1:0] hold1, hold2;
    logic              pending1, pending2;
    logic              last_grant, last_n;   // 0 = player 1, 1 = player 2
    logic [CODE_W-1:0] audio, audio_n;
    logic              audio_enable, en_n;
    logic              busy1, busy1_n, busy2, busy2_n;
    logic              grant1, grant2;
    logic              acc1, acc2;
    logic              cur_low, hi1, hi2, preempt;

    function automatic logic is_onehot(input logic [CODE_W-1:0] c);
        return (c != '0) && ((c & (c - CODE_W'(1))) == '0);
    endfunction

    assign acc1 = bus.req1_valid && !pending1;
    assign acc2 = bus.req2_valid && !pending2;

    // Preemption only targets the non-owner's pending clip, and only over a low-priority one.
    assign cur_low = (audio & PRIO_MASK) == '0;
    assign hi1     = pending1 && ((hold1 & PRIO_MASK) != '0);
    assign hi2     = pending2 && ((hold2 & PRIO_MASK) != '0);
    assign preempt = PREEMPT_EN && (state == PLAY) && cur_low && (busy1 ? hi2 : hi1);

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        audio_n = audio;
        en_n    = audio_enable;
        busy1_n = busy1;
        busy2_n = busy2;
        last_n  = last_grant;
        grant1  = 1'b0;
        grant2  = 1'b0;
        case (state)
            IDLE: begin
                if (pending1 && (!pending2 || last_grant)) grant1 = 1'b1;
                else if (pending2)                         grant2 = 1'b1;
            end
            PLAY: begin
                if (preempt) begin
                    if (busy1) grant2 = 1'b1;
                    else       grant1 = 1'b1;
                end else if (cnt == CLIP_CYCLES - 26'd1) begin
                    state_n = GAP;
                    audio_n = '0;
                    en_n    = 1'b0;
                    busy1_n = 1'b0;
                    busy2_n = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 26'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_CYCLES - 26'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 26'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A grant from IDLE or a preempt both start a fresh clip.
        if (grant1) begin
            state_n = PLAY;
            audio_n = hold1;
            en_n    = 1'b1;
            busy1_n = 1'b1;
            busy2_n = 1'b0;
            last_n  = 1'b0;
            cnt_n   = '0;
        end else if (grant2) begin
            state_n = PLAY;
            audio_n = hold2;
            en_n    = 1'b1;
            busy1_n = 1'b0;
            busy2_n = 1'b1;
            last_n  = 1'b1;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt          <= '0;
            audio        <= '0;
            audio_enable <= 1'b0;
            busy1        <= 1'b0;
            busy2        <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            cnt          <= cnt_n;
            audio        <= audio_n;
            audio_enable <= en_n;
            busy1        <= busy1_n;
            busy2        <= busy2_n;
            last_grant   <= last_n;
        end
    end

    // Accept and grant for the same player are exclusive: accept needs pending low, grant high.
    always_ff @(posedge clk) begin
        if (RST) begin
            pending1 <= 1'b0;
            pending2 <= 1'b0;
            hold1    <= '0;
            hold2    <= '0;
        end else begin
            if (acc1) begin
                if (is_onehot(bus.req1_code)) begin
                    pending1 <= 1'b1;
                    hold1    <= bus.req1_code;
                end
            end else if (grant1) begin
                pending1 <= 1'b0;
            end
            if (acc2) begin
                if (is_onehot(bus.req2_code)) begin
                    pending2 <= 1'b1;
                    hold2    <= bus.req2_code;
                end
            end else if (grant2) begin
                pending2 <= 1'b0;
            end
        end
    end

    assign bus.req1_ready   = ~pending1;
    assign bus.req2_ready   = ~pending2;
    assign bus.audio        = audio;
    assign bus.audio_enable = audio_enable;
    assign bus.busy_player1 = busy1;
    assign bus.busy_player2 = busy2;

endmodule
